// File: rtl/mmu_port_arbiter.sv
// mmu_port_arbiter
// Shares the single MMU memory port between the instruction-fetch (IF) and
// data (DM) requesters. One request is granted per cycle; on contention the
// requester that did not win last is granted. Outstanding reads are tracked
// through a LATENCY-deep {valid, owner} tag pipeline so each read response
// is routed back to the requester that issued it.
//
// Ports:
//   clk, rstb               clock, synchronous active-low reset
//   if_req/if_addr          fetch request (read-only)
//   if_gnt                  fetch accepted this cycle
//   if_rd_data/if_rd_valid  fetch read response
//   dm_req/dm_addr          data request
//   dm_wr_ena/dm_wr_data    store enable and store data
//   dm_gnt                  data request accepted this cycle
//   dm_rd_data/dm_rd_valid  load read response
//   mem_addr/mem_wr_ena/
//   mem_wr_data             MMU request lines (idle cycles drive 0)
//   mem_rd_data             MMU read data, valid LATENCY cycles after issue
//   if_stall_count          saturating count of cycles IF waited
//   dm_stall_count          saturating count of cycles DM waited
module mmu_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rd_data,
    output logic              if_rd_valid,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_wr_ena,
    input  logic [DATA_W-1:0] dm_wr_data,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rd_data,
    output logic              dm_rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_ena,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [CNT_W-1:0]  if_stall_count,
    output logic [CNT_W-1:0]  dm_stall_count
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    owner_e             last_q, last_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_own_q, tag_own_d;   // 1 = DM owns the slot
    logic [CNT_W-1:0]   if_cnt_q, if_cnt_d;
    logic [CNT_W-1:0]   dm_cnt_q, dm_cnt_d;

    logic issue_rd;
    logic rsp_vld;
    logic rsp_dm;

    // Grant: held off entirely while reset is asserted.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rstb) begin
            if (if_req && dm_req) begin
                if (last_q == OWN_IF) dm_gnt = 1'b1;
                else                  if_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_wr_ena  = 1'b0;
        mem_wr_data = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr    = dm_addr;
            mem_wr_ena  = dm_wr_ena;
            mem_wr_data = dm_wr_data;
        end
    end

    always_comb begin
        last_d = last_q;
        if (if_gnt)      last_d = OWN_IF;
        else if (dm_gnt) last_d = OWN_DM;
    end

    assign issue_rd = if_gnt | (dm_gnt & ~dm_wr_ena);

    // Tag pipeline: stage 0 takes this cycle's grant, the last stage lines
    // up with mem_rd_data for that grant.
    always_comb begin
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = issue_rd;
        tag_own_d[0] = dm_gnt;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    // Responses are suppressed in the reset cycle so reads issued before
    // reset never surface.
    assign rsp_vld = tag_vld_q[LATENCY-1] & rstb;
    assign rsp_dm  = tag_own_q[LATENCY-1];

    always_comb begin
        if_rd_valid = 1'b0;
        dm_rd_valid = 1'b0;
        if_rd_data  = '0;
        dm_rd_data  = '0;
        if (rsp_vld) begin
            if (rsp_dm) begin
                dm_rd_valid = 1'b1;
                dm_rd_data  = mem_rd_data;
            end else begin
                if_rd_valid = 1'b1;
                if_rd_data  = mem_rd_data;
            end
        end
    end

    always_comb begin
        if_cnt_d = if_cnt_q;
        dm_cnt_d = dm_cnt_q;
        if (if_req && !if_gnt && !(&if_cnt_q)) if_cnt_d = if_cnt_q + CNT_W'(1);
        if (dm_req && !dm_gnt && !(&dm_cnt_q)) dm_cnt_d = dm_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            last_q    <= OWN_IF;
            tag_vld_q <= '0;
            tag_own_q <= '0;
            if_cnt_q  <= '0;
            dm_cnt_q  <= '0;
        end else begin
            last_q    <= last_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
            if_cnt_q  <= if_cnt_d;
            dm_cnt_q  <= dm_cnt_d;
        end
    end

    assign if_stall_count = if_cnt_q;
    assign dm_stall_count = dm_cnt_q;

endmodule

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
Shares the single MMU memory port between the core's instruction-fetch requester and data (load/store) requester. Grants one request per cycle using round-robin on contention and drives the MMU address, write-data and write-enable lines. Tracks outstanding reads through a LATENCY-deep tag pipeline so each read response goes back to its issuer. Sits between the rv32i core and the MMU inside rv32i_system.

Parameters:
ADDR_W, 32, address width of both requesters and the MMU port
DATA_W, 32, data width
LATENCY, 1, MMU read latency in cycles from address presented to mem_rd_data valid (1..4)
CNT_W, 16, width of each saturating stall counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rstb  input  1  synchronous, active-low reset
if_req  input  1  instruction fetch request (read-only)
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch accepted this cycle
if_rd_data  output  DATA_W  fetch read data
if_rd_valid  output  1  if_rd_data valid
dm_req  input  1  data request
dm_addr  input  ADDR_W  data address
dm_wr_ena  input  1  1 = store, 0 = load
dm_wr_data  input  DATA_W  store data
dm_gnt  output  1  data request accepted this cycle
dm_rd_data  output  DATA_W  load read data
dm_rd_valid  output  1  dm_rd_data valid
mem_addr  output  ADDR_W  MMU address
mem_wr_ena  output  1  MMU write enable
mem_wr_data  output  DATA_W  MMU write data
mem_rd_data  input  DATA_W  MMU read data
if_stall_count  output  CNT_W  cycles if_req was high without if_gnt
dm_stall_count  output  CNT_W  cycles dm_req was high without dm_gnt

Behaviour:
- Reset (rstb=0 at a rising edge): last_winner <= IF (so first contention goes to DM); tag pipeline cleared to empty; both stall counters <= 0. This cancels in-flight reads: no rd_valid is raised for reads issued before reset. During reset, gnt outputs and mem_wr_ena are 0.
- Grants are combinational in the same cycle:
  - Only one requester asserting req: it is granted.
  - Both asserting req: grant goes to the requester that is not last_winner.
  - last_winner updates to the granted requester on each granted cycle; it holds on idle cycles.
  - if_gnt and dm_gnt are never both 1.
- Memory drive, combinational from the granted requester:
  - mem_addr = granted address; idle cycles drive 0.
  - mem_wr_ena = dm_wr_ena only when DM is granted, else 0.
  - mem_wr_data = dm_wr_data when DM is granted, else 0.
- Requester protocol: a requester holds req and its request fields stable until gnt is seen. The arbiter does not buffer requests.
- Tag pipeline: a LATENCY-stage shift register of {valid, owner}. A granted read (IF read, or DM with wr_ena=0) enters {1, owner}; writes and idle cycles enter {0, x}.
  - At the stage-LATENCY output, owner's rd_valid = 1 and rd_data = mem_rd_data.
  - The non-owner's rd_valid = 0 and its rd_data = 0.
  - Read latency from gnt to rd_valid is exactly LATENCY cycles. Back-to-back grants give back-to-back responses in issue order.
- Stall counters: increment on each cycle with req=1 and gnt=0. They saturate at all-ones and never wrap. They are held in reset.
- Sustained contention alternates IF, DM, IF, DM..., so neither requester waits more than 1 cycle.

Test Plan:
- Reset, then both requesters idle for 5 cycles -> gnt=0, mem_wr_ena=0, rd_valid=0, counters 0.
- Only if_req with if_addr=0x40; MMU returns 0x00500093 one cycle later (LATENCY=1) -> if_gnt same cycle, if_rd_valid=1 with 0x00500093 next cycle, dm_rd_valid=0.
- Both req held for 6 cycles after reset -> grants DM, IF, DM, IF, DM, IF. Each requester sees alternate grants; responses are tagged correctly; if_stall_count counts 1 for each cycle IF is denied, likewise dm_stall_count.
- DM store addr=0x1000 data=0xDEADBEEF contending with IF -> on DM's grant cycle mem_wr_ena=1 and mem_wr_data=0xDEADBEEF; no dm_rd_valid follows; IF is granted next cycle.
- LATENCY=3: IF read issued, rstb=0 on the following cycle -> no rd_valid ever emitted for that read; counters are 0 after reset.
- Hold dm_req with if_req winning is impossible, so force the counter: CNT_W=4 and 20 denied IF cycles via a test hook (dm-only arbiter bypass off) -> if_stall_count saturates at 15.
